// File: rtl/cm_pkg.sv
// cm_pkg: shared types and constants for the cm_job_master slice.
//   - cm_state_e     : job master FSM state encoding
//   - CM_*_W         : datapath widths toward the compute peer and response port
//   - CM_STATUS_OK   : status code a healthy peer reports
//   - sat_inc16      : saturating 16-bit increment used by statistics counters
package cm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } cm_state_e;

    localparam int CM_A_W    = 16;
    localparam int CM_B_W    = 8;
    localparam int CM_PROD_W = 32;
    localparam int CM_SUM_W  = 16;
    localparam int CM_ST_W   = 3;
    localparam int CM_BUS_W  = 4;

    localparam logic [CM_ST_W-1:0] CM_STATUS_OK = 3'b111;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        logic [15:0] res;
        if (val == 16'hFFFF) begin
            res = 16'hFFFF;
        end else begin
            res = val + 16'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/cm_timeout_counter.sv
// cm_timeout_counter: wait-cycle counter for the job master.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the count (used while the job is being issued)
//   enable     : count this cycle (asserted in WAIT)
//   expired    : this cycle is the last WAIT cycle allowed without done
// The count is kept as "cycles completed before this one"; expired looks at
// the incremented value so the counter reads TIMEOUT_CYCLES-1 on the final
// WAIT cycle, giving a response TIMEOUT_CYCLES cycles after start.
module cm_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_inc_s;

    assign cnt_inc_s = cnt_r + CNT_ONE;

    // Wait counter register: clear has priority over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            cnt_r <= cnt_inc_s;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_inc_s == CNT_LAST);

endmodule

// File: rtl/cm_job_master.sv
// cm_job_master: initiator for the start/done compute peer.
// Accepts a job (req_a, req_b) on a valid/ready port, issues it to the peer
// with a one-cycle start/data_valid pulse, waits for done with a timeout,
// then presents result_1/result_2/status (or zeros plus rsp_timeout) on a
// valid/ready response port. Also owns the far side of the shared 4-bit bus.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready/req_a/req_b  upstream job port
//   start/data_in_1/data_in_2/data_valid  issue to the peer
//   done/result_1/result_2/status    completion from the peer
//   bidirectional                    shared bus (driven only outside WAIT)
//   bus_oe/bus_tx/bus_rx             local bus drive request, value, sample
//   rsp_valid/rsp_ready/rsp_*        downstream response port
// Optional macro CM_MASTER_STATS_EN adds stat_jobs / stat_timeouts counters.
module cm_job_master
    import cm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [CM_A_W-1:0]     req_a,
    input  logic [CM_B_W-1:0]     req_b,
    output logic                  start,
    output logic [CM_A_W-1:0]     data_in_1,
    output logic [CM_B_W-1:0]     data_in_2,
    output logic                  data_valid,
    input  logic                  done,
    input  logic [CM_PROD_W-1:0]  result_1,
    input  logic [CM_SUM_W-1:0]   result_2,
    input  logic [CM_ST_W-1:0]    status,
    inout  wire  [CM_BUS_W-1:0]   bidirectional,
    input  logic                  bus_oe,
    input  logic [CM_BUS_W-1:0]   bus_tx,
    output logic [CM_BUS_W-1:0]   bus_rx,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [CM_PROD_W-1:0]  rsp_prod,
    output logic [CM_SUM_W-1:0]   rsp_sum,
    output logic [CM_ST_W-1:0]    rsp_status,
    output logic                  rsp_timeout
`ifdef CM_MASTER_STATS_EN
    ,
    output logic [15:0]           stat_jobs,
    output logic [15:0]           stat_timeouts
`endif
);

    cm_state_e state_r;
    cm_state_e state_s;

    logic accept_s;
    logic cnt_clear_s;
    logic cnt_en_s;
    logic cnt_expired_s;
    logic cap_done_s;
    logic cap_timeout_s;

    logic                 req_ready_r;
    logic                 start_r;
    logic [CM_A_W-1:0]    data_in_1_r;
    logic [CM_B_W-1:0]    data_in_2_r;
    logic                 rsp_valid_r;
    logic [CM_PROD_W-1:0] rsp_prod_r;
    logic [CM_SUM_W-1:0]  rsp_sum_r;
    logic [CM_ST_W-1:0]   rsp_status_r;
    logic                 rsp_timeout_r;
    logic                 drive_en_r;
    logic [CM_BUS_W-1:0]  bus_out_r;
    logic [CM_BUS_W-1:0]  bus_rx_r;

    cm_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear_s),
        .enable  (cnt_en_s),
        .expired (cnt_expired_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_s       = state_r;
        accept_s      = 1'b0;
        cnt_clear_s   = 1'b0;
        cnt_en_s      = 1'b0;
        cap_done_s    = 1'b0;
        cap_timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                // req_ready_r is low for the first cycle out of reset, so the
                // handshake is qualified by it rather than by state alone.
                if (req_valid && req_ready_r) begin
                    accept_s = 1'b1;
                    state_s  = ISSUE;
                end else begin
                    state_s  = IDLE;
                end
            end
            ISSUE: begin
                cnt_clear_s = 1'b1;
                state_s     = WAIT;
            end
            WAIT: begin
                cnt_en_s = 1'b1;
                // done wins over a coincident timeout.
                if (done) begin
                    cap_done_s = 1'b1;
                    state_s    = RESP;
                end else if (cnt_expired_s) begin
                    cap_timeout_s = 1'b1;
                    state_s       = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Registered outputs, decoded from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_r   <= 1'b0;
            start_r       <= 1'b0;
            rsp_valid_r   <= 1'b0;
            data_in_1_r   <= {CM_A_W{1'b0}};
            data_in_2_r   <= {CM_B_W{1'b0}};
            rsp_prod_r    <= {CM_PROD_W{1'b0}};
            rsp_sum_r     <= {CM_SUM_W{1'b0}};
            rsp_status_r  <= {CM_ST_W{1'b0}};
            rsp_timeout_r <= 1'b0;
        end else begin
            req_ready_r <= (state_s == IDLE);
            start_r     <= (state_s == ISSUE);
            rsp_valid_r <= (state_s == RESP);
            if (accept_s) begin
                data_in_1_r <= req_a;
                data_in_2_r <= req_b;
            end
            if (cap_done_s) begin
                rsp_prod_r    <= result_1;
                rsp_sum_r     <= result_2;
                rsp_status_r  <= status;
                rsp_timeout_r <= 1'b0;
            end else if (cap_timeout_s) begin
                rsp_prod_r    <= {CM_PROD_W{1'b0}};
                rsp_sum_r     <= {CM_SUM_W{1'b0}};
                rsp_status_r  <= {CM_ST_W{1'b0}};
                rsp_timeout_r <= 1'b1;
            end
        end
    end

    // Bus drive and sample. The enable is registered from the next state so
    // the pad is already released on the first WAIT cycle, when the peer may
    // start driving, and is released during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drive_en_r <= 1'b0;
            bus_out_r  <= {CM_BUS_W{1'b0}};
            bus_rx_r   <= {CM_BUS_W{1'b0}};
        end else begin
            drive_en_r <= bus_oe && (state_s != WAIT);
            bus_out_r  <= bus_tx;
            bus_rx_r   <= bidirectional;
        end
    end

    assign bidirectional = drive_en_r ? bus_out_r : {CM_BUS_W{1'bz}};

`ifdef CM_MASTER_STATS_EN
    logic [15:0] stat_jobs_r;
    logic [15:0] stat_timeouts_r;

    // Saturating counters of accepted responses and of accepted timeouts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_jobs_r     <= 16'd0;
            stat_timeouts_r <= 16'd0;
        end else if (rsp_valid_r && rsp_ready) begin
            stat_jobs_r <= sat_inc16(stat_jobs_r);
            if (rsp_timeout_r) begin
                stat_timeouts_r <= sat_inc16(stat_timeouts_r);
            end
        end
    end

    assign stat_jobs     = stat_jobs_r;
    assign stat_timeouts = stat_timeouts_r;
`endif

    assign req_ready   = req_ready_r;
    assign start       = start_r;
    assign data_valid  = start_r;
    assign data_in_1   = data_in_1_r;
    assign data_in_2   = data_in_2_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_prod    = rsp_prod_r;
    assign rsp_sum     = rsp_sum_r;
    assign rsp_status  = rsp_status_r;
    assign rsp_timeout = rsp_timeout_r;
    assign bus_rx      = bus_rx_r;

endmodule

// File: tb/tb_cm_job_master.sv
// Self-checking bench for cm_job_master: table-driven job vectors, hand
// sequences for the bus and mid-job reset, then randomized jobs checked
// against a job-level reference model (peer function + timeout rule).
module tb_cm_job_master;
    import cm_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_a = 16'd0;
    logic [7:0]  req_b = 8'd0;
    logic        start;
    logic [15:0] data_in_1;
    logic [7:0]  data_in_2;
    logic        data_valid;
    logic        done = 1'b0;
    logic [31:0] result_1 = 32'd0;
    logic [15:0] result_2 = 16'd0;
    logic [2:0]  status = 3'd0;
    wire  [3:0]  bus_w;
    logic        bus_oe = 1'b0;
    logic [3:0]  bus_tx = 4'd0;
    logic [3:0]  bus_rx;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_prod;
    logic [15:0] rsp_sum;
    logic [2:0]  rsp_status;
    logic        rsp_timeout;
    logic        peer_drive = 1'b0;
    logic [3:0]  peer_bus = 4'd0;
`ifdef CM_MASTER_STATS_EN
    logic [15:0] stat_jobs;
    logic [15:0] stat_timeouts;
`endif

    int checks = 0;
    int errors = 0;
    int m_jobs = 0;
    int m_tos  = 0;

    assign bus_w = peer_drive ? peer_bus : 4'bzzzz;

    always #5 clk = ~clk;

    cm_job_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .start(start), .data_in_1(data_in_1), .data_in_2(data_in_2), .data_valid(data_valid),
        .done(done), .result_1(result_1), .result_2(result_2), .status(status),
        .bidirectional(bus_w), .bus_oe(bus_oe), .bus_tx(bus_tx), .bus_rx(bus_rx),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_prod(rsp_prod),
        .rsp_sum(rsp_sum), .rsp_status(rsp_status), .rsp_timeout(rsp_timeout)
`ifdef CM_MASTER_STATS_EN
        , .stat_jobs(stat_jobs), .stat_timeouts(stat_timeouts)
`endif
    );

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        int          k;     // WAIT-cycle index at which the peer raises done
        int          bp;    // cycles of rsp_ready=0 once rsp_valid is seen
        bit          pre;   // rsp_ready already high before RESP
        logic [2:0]  st;
        logic [31:0] prod;
        logic [15:0] sum;
        logic [2:0]  est;
        logic        eto;
        int          lat;   // cycles from start to rsp_valid
    } vec_t;

    vec_t tbl[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Peer function used by the bench: square of A, twice B.
    function automatic logic [31:0] peer_prod(input logic [15:0] a);
        logic signed [31:0] x;
        x = 32'(signed'(a));
        return x * x;
    endfunction

    function automatic logic [15:0] peer_sum(input logic [7:0] b);
        return 16'(b) + 16'(b);
    endfunction

    task automatic run_job(input vec_t v);
        int  t;
        int  guard;
        bit  seen;
        logic [31:0] p0;
        logic [15:0] s0;
        guard = 0;
        while (!req_ready && guard < 50) begin
            tick();
            guard++;
        end
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        rsp_ready = v.pre;
        req_valid = 1'b1;
        req_a = v.a;
        req_b = v.b;
        tick();
        req_valid = 1'b0;
        req_a = 16'($urandom);
        req_b = 8'($urandom);
        chk("start", 32'(start), 32'd1);
        chk("data_valid", 32'(data_valid), 32'd1);
        chk("data_in_1", 32'(data_in_1), 32'(v.a));
        chk("data_in_2", 32'(data_in_2), 32'(v.b));
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        t = 0;
        seen = 1'b0;
        while (!seen && t < TO + 4) begin
            done = (t == v.k + 1);
            result_1 = done ? peer_prod(v.a) : $urandom;
            result_2 = done ? peer_sum(v.b) : 16'($urandom);
            status   = done ? v.st : 3'($urandom);
            tick();
            t++;
            if (rsp_valid) seen = 1'b1;
        end
        chk("rsp_latency", 32'(t), 32'(v.lat));
        chk("rsp_prod", rsp_prod, v.prod);
        chk("rsp_sum", 32'(rsp_sum), 32'(v.sum));
        chk("rsp_status", 32'(rsp_status), 32'(v.est));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(v.eto));
        p0 = rsp_prod;
        s0 = rsp_sum;
        for (int i = 0; i < v.bp; i++) begin
            done = 1'($urandom);
            result_1 = $urandom;
            result_2 = 16'($urandom);
            tick();
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_prod_stable", rsp_prod, p0);
            chk("bp_sum_stable", 32'(rsp_sum), 32'(s0));
        end
        done = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("post_hs_valid", 32'(rsp_valid), 32'd0);
        chk("post_hs_req_ready", 32'(req_ready), 32'd1);
        chk("data_in_1_hold", 32'(data_in_1), 32'(v.a));
        m_jobs++;
        if (v.eto) m_tos++;
    endtask

    initial begin
        vec_t v;
        int guard;
        //               a        b      k   bp pre st            prod          sum     est           eto  lat
        tbl[0] = '{16'hFFFD, 8'd200,  0,  0, 1'b0, CM_STATUS_OK, 32'd9,         16'd400, CM_STATUS_OK, 1'b0, 2};
        tbl[1] = '{16'h0005, 8'd3,   99,  0, 1'b0, CM_STATUS_OK, 32'd0,         16'd0,   3'd0,         1'b1, TO};
        tbl[2] = '{16'h0064, 8'd5,    3,  5, 1'b0, CM_STATUS_OK, 32'd10000,     16'd10,  CM_STATUS_OK, 1'b0, 5};
        tbl[3] = '{16'h8000, 8'd255, 14,  1, 1'b0, 3'b010,       32'h40000000,  16'd510, 3'b010,       1'b0, TO};
        tbl[4] = '{16'h0007, 8'd1,   15,  0, 1'b0, CM_STATUS_OK, 32'd0,         16'd0,   3'd0,         1'b1, TO};
        tbl[5] = '{16'hFFFF, 8'd0,    1,  0, 1'b1, 3'b101,       32'd1,         16'd0,   3'b101,       1'b0, 3};
        tbl[6] = '{16'h0002, 8'd9,   20,  0, 1'b1, CM_STATUS_OK, 32'd0,         16'd0,   3'd0,         1'b1, TO};
        tbl[7] = '{16'h7FFF, 8'd128, 13,  2, 1'b0, CM_STATUS_OK, 32'h3FFF0001,  16'd256, CM_STATUS_OK, 1'b0, 15};

        // Reset state.
        repeat (3) tick();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_prod", rsp_prod, 32'd0);
        chk("rst_bus_rx", 32'(bus_rx), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 8; i++) run_job(tbl[i]);

        // Bus ownership around a job that times out.
        bus_oe = 1'b1;
        bus_tx = 4'hA;
        tick();
        tick();
        chk("bus_idle_drive", 32'(bus_w), 32'hA);
        req_valid = 1'b1;
        req_a = 16'd1;
        req_b = 8'd1;
        tick();
        req_valid = 1'b0;
        tick();
        peer_drive = 1'b1;
        peer_bus = 4'h5;
        #1;
        chk("bus_wait_released", 32'(bus_w), 32'h5);
        tick();
        chk("bus_rx_sample", 32'(bus_rx), 32'h5);
        peer_drive = 1'b0;
        guard = 0;
        while (!rsp_valid && guard < TO + 4) begin
            tick();
            guard++;
        end
        chk("bus_job_timeout", 32'(rsp_timeout), 32'd1);
        chk("bus_resp_drive", 32'(bus_w), 32'hA);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        m_jobs++;
        m_tos++;

        // Reset asserted mid-job in WAIT.
        req_valid = 1'b1;
        req_a = 16'd3;
        req_b = 8'd4;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        peer_drive = 1'b1;
        peer_bus = 4'h5;
        rst_n = 1'b0;
        #1;
        chk("midrst_start", 32'(start), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_bus", 32'(bus_w), 32'h5);
        tick();
        chk("midrst_bus_held", 32'(bus_w), 32'h5);
        rst_n = 1'b1;
        peer_drive = 1'b0;
        tick();
        chk("midrst_idle", 32'(req_ready), 32'd1);
        chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        m_jobs = 0;
        m_tos = 0;
        bus_oe = 1'b0;
        run_job(tbl[0]);

        // Randomized jobs against the job-level model.
        for (int n = 0; n < 30; n++) begin
            v.a   = 16'($urandom);
            v.b   = 8'($urandom);
            v.k   = $urandom_range(0, TO + 1);
            v.pre = ($urandom_range(0, 3) == 0);
            v.bp  = v.pre ? 0 : $urandom_range(0, 3);
            v.st  = 3'($urandom);
            if (v.k <= TO - 2) begin
                v.prod = peer_prod(v.a);
                v.sum  = peer_sum(v.b);
                v.est  = v.st;
                v.eto  = 1'b0;
                v.lat  = v.k + 2;
            end else begin
                v.prod = 32'd0;
                v.sum  = 16'd0;
                v.est  = 3'd0;
                v.eto  = 1'b1;
                v.lat  = TO;
            end
            run_job(v);
        end

`ifdef CM_MASTER_STATS_EN
        chk("stat_jobs", 32'(stat_jobs), 32'(m_jobs));
        chk("stat_timeouts", 32'(stat_timeouts), 32'(m_tos));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
